// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC constants, FSM encoding and quadrant map
package cordic_pkg;
   typedef enum logic [1:0] {IDLE, ROT, FIX, HOLD} state_t;
   // per quadrant {swap c/s, negate cosine, negate sine}, q3 in the MSBs
   localparam logic [11:0] QMAP = {3'b101, 3'b011, 3'b110, 3'b000};
   function automatic longint atan_f(input int i, input int bits);
      return longint'($atan(2.0 ** (-i)) * (2.0 ** bits) / (2.0 * 3.14159265358979323846));
   endfunction
   function automatic longint gain_f(input int fbits);
      return longint'(0.6072529350 * (2.0 ** fbits));
   endfunction
endpackage

// File: rtl/cordic_iter_if.sv
// cordic_iter_if: angle-in / sine-cosine-out valid/ready bundle
interface cordic_iter_if #(parameter int WIDTH = 16);
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] angle, sine, cosine;
   modport slave (input in_valid, angle, out_ready, output in_ready, out_valid, sine, cosine);
   modport master (output in_valid, angle, out_ready, input in_ready, out_valid, sine, cosine);
endinterface

// File: rtl/cordic_microrot.sv
// cordic_microrot: one combinational CORDIC micro-rotation step
module cordic_microrot #(parameter int IW = 19) (
   input  logic signed [IW-1:0] i_x,
   input  logic signed [IW-1:0] i_y,
   input  logic signed [IW-1:0] i_z,
   input  logic signed [IW-1:0] i_atan,
   input  logic [4:0]           i_sh,
   output logic signed [IW-1:0] o_x,
   output logic signed [IW-1:0] o_y,
   output logic signed [IW-1:0] o_z
);
   logic signed [IW-1:0] w_xs, w_ys;
   logic                 w_neg;
   always_comb begin
      w_neg = i_z[IW-1];
      w_xs  = i_x >>> i_sh;
      w_ys  = i_y >>> i_sh;
      o_x   = w_neg ? i_x + w_ys : i_x - w_ys;
      o_y   = w_neg ? i_y - w_xs : i_y + w_xs;
      o_z   = w_neg ? i_z + i_atan : i_z - i_atan;
   end
endmodule

// File: rtl/cordic_iter.sv
// cordic_iter: iterative handshaked CORDIC sine/cosine generator, one micro-rotation per clock
module cordic_iter
   import cordic_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int ITERATIONS = 14,
   parameter int GUARD      = 2
) (
   input logic          clk,
   input logic          rst_n,
   cordic_iter_if.slave bus
);
   localparam int IW = WIDTH + GUARD + 1;
   localparam int CW = $clog2(ITERATIONS);
   localparam logic signed [IW-1:0] KX   = IW'(gain_f(WIDTH - 2 + GUARD));
   localparam logic signed [IW-1:0] HALF = IW'(2 ** (GUARD - 1));
   state_t               r_state, w_next;
   logic [CW-1:0]        r_cnt;
   logic [1:0]           r_q;
   logic signed [IW-1:0] r_x, r_y, r_z, w_x, w_y, w_z;
   logic signed [IW-1:0] w_atan [ITERATIONS];
   logic [WIDTH-1:0]     r_sin, r_cos, w_c, w_s, w_a, w_b;
   logic [2:0]           w_map;
   logic                 w_acc, w_last;
   for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
      assign w_atan[g] = IW'(atan_f(g, WIDTH + GUARD));
   end
   cordic_microrot #(.IW(IW)) u_rot (
      .i_x(r_x), .i_y(r_y), .i_z(r_z), .i_atan(w_atan[r_cnt]), .i_sh(5'(r_cnt)),
      .o_x(w_x), .o_y(w_y), .o_z(w_z)
   );
   always_comb begin
      bus.in_ready = (r_state == IDLE) || (r_state == HOLD && bus.out_ready);
      w_acc  = bus.in_valid && bus.in_ready;
      w_last = r_cnt == CW'(ITERATIONS - 1);
      w_next = (r_state == IDLE) ? (bus.in_valid ? ROT : IDLE)
             : (r_state == ROT)  ? (w_last ? FIX : ROT)
             : (r_state == FIX)  ? HOLD
             : bus.out_ready     ? (bus.in_valid ? ROT : IDLE) : HOLD;
      // round-half-up from the guarded datapath back to WIDTH
      w_c   = WIDTH'((r_x + HALF) >>> GUARD);
      w_s   = WIDTH'((r_y + HALF) >>> GUARD);
      w_map = QMAP[3*r_q +: 3];
      w_a   = w_map[2] ? w_s : w_c;
      w_b   = w_map[2] ? w_c : w_s;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_q     <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_sin   <= '0;
         r_cos   <= '0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_q   <= bus.angle[WIDTH-1 -: 2];
            r_x   <= KX;
            r_y   <= '0;
            r_z   <= IW'({2'b00, bus.angle[WIDTH-3:0], {GUARD{1'b0}}});
            r_cnt <= '0;
         end else if (r_state == ROT) begin
            r_x   <= w_x;
            r_y   <= w_y;
            r_z   <= w_z;
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == FIX) begin
            r_cos <= w_map[1] ? -w_a : w_a;
            r_sin <= w_map[0] ? -w_b : w_b;
         end
      end
   assign bus.out_valid = r_state == HOLD;
   assign bus.sine      = r_sin;
   assign bus.cosine    = r_cos;
endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: scoreboard bench checking cordic_iter against a real-valued sine/cosine model
module tb_cordic_iter;
   localparam int W = 16, N = 14;
   typedef struct { int a; int c; } exp_t;
   logic clk = 0, rst_n = 1;
   int   cyc = 0, ncmp = 0, nbad = 0, nacc = 0, nres = 0;
   bit   or_rand = 0;
   exp_t q[$];
   exp_t e;
   bit   pv, pr;
   logic [W-1:0] ps, pc;
   real  th, rs, rc;
   int   s, c;
   logic [W-1:0] dir [7] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h2000, 16'hE000, 16'hFFFF};

   cordic_iter_if #(.WIDTH(W)) bus ();
   cordic_iter #(.WIDTH(W), .ITERATIONS(N), .GUARD(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (or_rand) bus.out_ready = 1'($urandom_range(0, 1));

   task automatic chk(input bit ok, input string nm, input int act, input int req);
      ncmp++;
      if (!ok) begin
         nbad++;
         $display("FAIL %s: got %0d want %0d", nm, act, req);
      end
   endtask

   task automatic send(input logic [W-1:0] a, output int waited);
      bus.in_valid = 1;
      bus.angle = a;
      waited = -1;
      for (int t = 0; t < 400; t++) begin
         #1;
         if (bus.in_ready) begin
            q.push_back('{a: int'(a), c: cyc});
            nacc++;
            waited = t;
            @(negedge clk);
            bus.in_valid = 0;
            return;
         end
         @(negedge clk);
      end
      chk(0, "accept_timeout", 0, 1);
      bus.in_valid = 0;
   endtask

   task automatic drain();
      for (int t = 0; t < 2000 && q.size() > 0; t++) @(negedge clk);
      chk(q.size() == 0, "drain_timeout", q.size(), 0);
   endtask

   task automatic wait_valid(input string nm);
      for (int t = 0; t < 100 && !bus.out_valid; t++) @(negedge clk);
      chk(bus.out_valid == 1, nm, int'(bus.out_valid), 1);
   endtask

   task automatic do_reset(input string nm);
      rst_n = 0;
      #1;
      chk(bus.out_valid == 0, {nm, "_out_valid"}, int'(bus.out_valid), 0);
      chk(bus.sine == 0, {nm, "_sine"}, int'($signed(bus.sine)), 0);
      chk(bus.cosine == 0, {nm, "_cosine"}, int'($signed(bus.cosine)), 0);
      chk(bus.in_ready == 1, {nm, "_in_ready"}, int'(bus.in_ready), 1);
      nacc -= q.size();
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   always @(negedge clk) begin
      #2;
      if (!rst_n) pv = 0;
      else begin
         if (bus.out_valid && !pv) begin
            if (q.size() == 0) chk(0, "spurious_result", 1, 0);
            else chk(cyc - q[0].c == N + 2, "latency", cyc - q[0].c, N + 2);
         end
         if (pv && !pr) begin
            chk(bus.out_valid == 1, "stall_valid", int'(bus.out_valid), 1);
            chk(bus.sine == ps && bus.cosine == pc, "stall_stable", int'($signed(bus.sine)), int'($signed(ps)));
         end
         if (bus.out_valid && !bus.out_ready) chk(!bus.in_ready, "stall_in_ready", int'(bus.in_ready), 0);
         if (q.size() > 0 && !bus.out_valid && q[$].c != cyc) chk(!bus.in_ready, "busy_in_ready", int'(bus.in_ready), 0);
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk(0, "extra_result", 1, 0);
            else begin
               e = q.pop_front();
               nres++;
               th = 2.0 * 3.14159265358979 * real'(e.a) / (2.0 ** W);
               rs = $sin(th) * (2.0 ** (W - 2));
               rc = $cos(th) * (2.0 ** (W - 2));
               s = int'($signed(bus.sine));
               c = int'($signed(bus.cosine));
               chk(real'(s) - rs <= 4.0 && rs - real'(s) <= 4.0, $sformatf("sine_%h", e.a), s, $rtoi(rs));
               chk(real'(c) - rc <= 4.0 && rc - real'(c) <= 4.0, $sformatf("cosine_%h", e.a), c, $rtoi(rc));
            end
         end
         pv = bus.out_valid;
         pr = bus.out_ready;
         ps = bus.sine;
         pc = bus.cosine;
      end
   end

   initial begin
      int w;
      bus.in_valid = 0;
      bus.angle = '0;
      bus.out_ready = 1;
      @(negedge clk);
      do_reset("reset");
      foreach (dir[i]) begin
         send(dir[i], w);
         drain();
      end
      bus.out_ready = 0;
      send(16'h1234, w);
      wait_valid("bp_valid");
      bus.in_valid = 1;
      bus.angle = 16'h5555;
      repeat (10) @(negedge clk);
      bus.out_ready = 1;
      send(16'h5555, w);
      chk(w == 0, "bp_same_cycle_accept", w, 0);
      drain();
      send(16'h3000, w);
      repeat (5) @(negedge clk);
      do_reset("rot_reset");
      send(16'h3000, w);
      drain();
      bus.out_ready = 0;
      send(16'h6000, w);
      wait_valid("hold_valid");
      repeat (3) @(negedge clk);
      do_reset("hold_reset");
      bus.out_ready = 1;
      send(16'h9000, w);
      drain();
      or_rand = 1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
         send(W'($urandom), w);
      end
      drain();
      or_rand = 0;
      bus.out_ready = 1;
      chk(nres == nacc, "result_count", nres, nacc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule

// File: doc/cordic_iter.md
Name: cordic_iter

Overview:
- Parametrised, handshaked, iterative CORDIC sine/cosine generator. Successor to the fixed 32-bit combinational quadrant-select block.
- Performs one micro-rotation per clock, applies full-circle quadrant correction, and returns the signed sine and cosine of a binary angle.
- Sits between the phase-accumulator/NCO front end and the mixer datapath.
- Valid/ready on input and output so upstream and downstream can stall.

Parameters:
- WIDTH, 16: angle and output width in bits; legal range 8..32.
- ITERATIONS, 14: number of micro-rotations; legal range 4..WIDTH-2.
- GUARD, 2: extra LSBs carried on the internal x/y/z datapath.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  angle present.
- in_ready  out  1  block can accept an angle this cycle.
- angle  in  WIDTH  unsigned binary angle; full circle = 2^WIDTH (0x4000 = 90 deg at WIDTH=16).
- out_valid  out  1  sine/cosine valid; held until taken.
- out_ready  in  1  downstream accepts the result.
- sine  out  WIDTH  signed Q1.(WIDTH-2); 1.0 = 2^(WIDTH-2).
- cosine  out  WIDTH  signed Q1.(WIDTH-2).

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, in_ready=1, out_valid=0, sine=0, cosine=0, iteration counter=0, x/y/z=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch the angle, go to ROT.
  - ROT: perform one iteration per cycle; counter runs 0..ITERATIONS-1; on the last iteration go to FIX.
  - FIX: apply the quadrant map, register sine/cosine, set out_valid, go to HOLD.
  - HOLD: out_valid=1, outputs frozen. On out_ready go to IDLE, or straight to ROT if a new angle is accepted in the same cycle.
- Handshake:
  - in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - Transfer occurs on in_valid && in_ready.
  - in_valid while busy is ignored, not queued.
- Latency: out_valid rises exactly ITERATIONS+2 rising edges after the accepting edge (accept edge, ITERATIONS rotate edges, FIX edge).
- Throughput: one result per ITERATIONS+2 cycles with out_ready held high.
- Load on accept:
  - q = angle[WIDTH-1:WIDTH-2].
  - z = {00, angle[WIDTH-3:0]} extended with GUARD zero LSBs (residual in [0, 90 deg)).
  - x = K (prescaled gain 0.6072529350, rounded to the internal width).
  - y = 0.
- Iteration i:
  - d = sign(z).
  - x' = x - d*(y>>>i).
  - y' = y + d*(x>>>i).
  - z' = z - d*atan_i.
  - Arithmetic shifts; internal width WIDTH+GUARD+1 signed; no saturation needed because |x|,|y| < 1.7.
- Quadrant map, with c,s = final x,y rounded (round-half-up) back to WIDTH:
  - q0: cos=c, sin=s.
  - q1: cos=-s, sin=c.
  - q2: cos=-c, sin=-s.
  - q3: cos=s, sin=-c.
- Negation of the most negative value cannot occur because magnitudes are ≤ 2^(WIDTH-2)+tolerance.
- Accuracy: |error| ≤ 4 LSB at defaults for every angle.
- Boundaries:
  - angle=0 and the quadrant edges (0x4000, 0x8000, 0xC000) resolve via q with residual 0.
  - angle wrap: 0xFFFF is just below 360 deg.
  - Reset mid-ROT or mid-HOLD aborts immediately with no output; the result is discarded.
  - out_ready while out_valid=0 has no effect.

Decomposition:
- Package cordic_pkg holds:
  - a function returning atan(2^-i) scaled to 2^(WIDTH+GUARD)/(2*pi), rounded, for i=0..31;
  - a function returning K scaled to the internal width;
  - a state enum {IDLE, ROT, FIX, HOLD};
  - a quadrant map localparam.
- One sub-module, cordic_microrot: combinational single micro-rotation (x, y, z, shift amount i, atan_i in; x', y', z' out). Instantiated once and reused each ROT cycle.

Test Plan:
- Reset, then angle=0x0000 at WIDTH=16 -> after 16 cycles: cosine=16384±4, sine=0±4, in_ready low throughout.
- angle=0x4000 -> sine=16384±4, cosine=0±4. angle=0x8000 -> cosine=-16384±4, sine=0±4. angle=0xC000 -> sine=-16384±4.
- angle=0x2000 (45 deg) -> sine=cosine=11585±4. angle=0xE000 -> sine=-11585±4, cosine=11585±4.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored. Release with in_valid high -> next angle accepted the same cycle.
- Reset asserted at ROT iteration 5 -> out_valid=0 and outputs 0 immediately. Next angle after release gives a correct result with no leftover state.
- Random sweep of 10k angles with out_ready toggling, WIDTH=16 and WIDTH=24/ITERATIONS=22 -> every result within tolerance versus a real-valued model; result count equals accept count.
